// File: rtl/prog_clk_divider_if.sv
// prog_clk_divider_if: divisor configuration handshake (valid/ready plus reject pulse)
interface prog_clk_divider_if #(parameter int W = 8);
  logic         cfg_valid;
  logic [W-1:0] cfg_div;
  logic         cfg_ready;
  logic         cfg_err;
  modport master (output cfg_valid, cfg_div, input cfg_ready, cfg_err);
  modport slave  (input cfg_valid, cfg_div, output cfg_ready, cfg_err);
endinterface

// File: rtl/prog_clk_divider.sv
// prog_clk_divider: runtime-programmable integer clock divider with tick strobe
module prog_clk_divider #(
  parameter int W           = 8,
  parameter int DEFAULT_DIV = 16
) (
  input  logic                 clk_in,
  input  logic                 rstn,
  input  logic                 en,
  prog_clk_divider_if.slave    cfg,
  output logic                 clk_out,
  output logic                 tick,
  output logic [W-1:0]         cur_div
);
  logic [W-1:0] cnt, cnt_nxt, pend_div, div_nxt;
  logic [W:0]   hi;
  logic         pending, boundary, accept;
  always_comb begin
    boundary = en && (cnt == cur_div - W'(1));
    accept   = cfg.cfg_valid && !pending;
    cnt_nxt  = boundary ? '0 : cnt + W'(1);
    div_nxt  = (boundary && pending) ? pend_div : cur_div;
    hi       = ({1'b0, div_nxt} + (W+1)'(1)) >> 1;
  end
  assign cfg.cfg_ready = !pending;
  always_ff @(posedge clk_in) begin
    if (!rstn) begin
      cnt         <= W'(DEFAULT_DIV - 1);
      clk_out     <= 1'b0;
      tick        <= 1'b0;
      cur_div     <= W'(DEFAULT_DIV);
      pend_div    <= W'(DEFAULT_DIV);
      pending     <= 1'b0;
      cfg.cfg_err <= 1'b0;
    end else begin
      tick        <= en && (cnt_nxt == '0);
      cfg.cfg_err <= accept && (cfg.cfg_div < W'(2));
      if (en) begin
        cnt     <= cnt_nxt;
        clk_out <= {1'b0, cnt_nxt} < hi;
      end
      // apply (pending=1) and accept (pending=0) are mutually exclusive on any edge
      if (boundary && pending) begin
        cur_div <= pend_div;
        pending <= 1'b0;
      end else if (accept && cfg.cfg_div >= W'(2)) begin
        pend_div <= cfg.cfg_div;
        pending  <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_prog_clk_divider.sv
// tb_prog_clk_divider: directed + random stimulus against a waveform-queue reference model
module tb_prog_clk_divider;
  localparam int W  = 4;
  localparam int DD = 4;
  logic         clk_in = 1'b0;
  logic         rstn, en, clk_out, tick;
  logic [W-1:0] cur_div;
  int           tests = 0, fails = 0;
  prog_clk_divider_if #(.W(W)) cfg ();
  prog_clk_divider #(.W(W), .DEFAULT_DIV(DD)) dut (
    .clk_in(clk_in), .rstn(rstn), .en(en), .cfg(cfg.slave),
    .clk_out(clk_out), .tick(tick), .cur_div(cur_div)
  );
  always #5 clk_in = ~clk_in;
  // model: each period is materialised as a queue of {tick,clk_out} samples
  logic [1:0] wave[$];
  int         m_div = DD, m_pdiv = 0;
  logic       m_pend = 1'b0, m_clk = 1'b0, m_tick = 1'b0, m_err = 1'b0;
  task automatic model_edge(input logic r, input logic e, input logic v, input int d);
    logic acc;
    logic [1:0] s;
    if (!r) begin
      wave.delete();
      m_div = DD; m_pend = 0; m_clk = 0; m_tick = 0; m_err = 0;
      return;
    end
    acc = v && !m_pend;
    m_err = 0;
    m_tick = 0;
    if (e) begin
      if (wave.size() == 0) begin
        if (m_pend) begin
          m_div = m_pdiv;
          m_pend = 0;
        end
        for (int i = 0; i < m_div; i++) wave.push_back({i == 0, i < (m_div + 1) / 2});
      end
      s = wave.pop_front();
      m_tick = s[1];
      m_clk = s[0];
    end
    if (acc) begin
      if (d >= 2) begin
        m_pend = 1;
        m_pdiv = d;
      end else m_err = 1;
    end
  endtask
  task automatic step(input logic r, input logic e, input logic v, input int d);
    rstn = r; en = e; cfg.cfg_valid = v; cfg.cfg_div = W'(d);
    @(posedge clk_in);
    model_edge(r, e, v, d);
    #1;
    tests += 5;
    assert (clk_out === m_clk) else begin fails++; $error("FAIL clk_out got %0b exp %0b", clk_out, m_clk); end
    assert (tick === m_tick) else begin fails++; $error("FAIL tick got %0b exp %0b", tick, m_tick); end
    assert (cur_div === W'(m_div)) else begin fails++; $error("FAIL cur_div got %0d exp %0d", cur_div, m_div); end
    assert (cfg.cfg_ready === !m_pend) else begin fails++; $error("FAIL cfg_ready got %0b exp %0b", cfg.cfg_ready, !m_pend); end
    assert (cfg.cfg_err === m_err) else begin fails++; $error("FAIL cfg_err got %0b exp %0b", cfg.cfg_err, m_err); end
  endtask
  initial begin
    rstn = 0; en = 0; cfg.cfg_valid = 0; cfg.cfg_div = '0;
    step(0, 0, 0, 0);
    step(0, 1, 0, 0);
    step(1, 0, 0, 0);
    for (int i = 0; i < 12; i++) step(1, 1, 0, 0);
    step(1, 1, 1, 5);
    step(1, 1, 1, 9);
    for (int i = 0; i < 12; i++) step(1, 1, 0, 0);
    step(1, 1, 1, 6);
    for (int i = 0; i < 14; i++) step(1, 1, 0, 0);
    step(1, 1, 1, 1);
    step(1, 1, 0, 0);
    step(1, 1, 1, 0);
    for (int i = 0; i < 4; i++) step(1, 1, 0, 0);
    step(1, 1, 1, 3);
    for (int i = 0; i < 7; i++) step(1, 0, 0, 0);
    for (int i = 0; i < 12; i++) step(1, 1, 0, 0);
    step(1, 1, 1, 15);
    for (int i = 0; i < 40; i++) step(1, 1, 0, 0);
    step(0, 1, 0, 0);
    for (int i = 0; i < 9; i++) step(1, 1, 0, 0);
    step(1, 1, 1, 2);
    for (int i = 0; i < 8; i++) step(1, 1, 0, 0);
    for (int i = 0; i < 2000; i++)
      step($urandom_range(99) != 0, $urandom_range(4) != 0, $urandom_range(9) == 0, int'($urandom_range(15)));
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
